// File: rtl/bird_physics_fx.sv
// Fixed-point vertical physics for the player bird: gravity, jumps, ceiling clamp,
// floor and pipe collisions, with an INIT/FLY/DEAD life cycle.
module bird_physics_fx #(
   parameter int unsigned POS_W    = 10,
   parameter int unsigned FRAC_W   = 4,
   parameter int unsigned V_W      = 10,
   parameter int unsigned GRAVITY  = 6,
   parameter int unsigned JUMP_VEL = 96,
   parameter int unsigned MAX_FALL = 128,
   parameter int unsigned Y_MIN    = 0,
   parameter int unsigned Y_MAX    = 464,
   parameter int unsigned START_X  = 160,
   parameter int unsigned START_Y  = 240
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             Ack,
   input  logic             FrameTick,
   input  logic             BtnPress,
   input  logic             Collide,
   output logic [POS_W-1:0] Bird_X,
   output logic [POS_W-1:0] Bird_Y,
   output logic [V_W-1:0]   VertSpeed,
   output logic [1:0]       State,
   output logic             Hit
);

   localparam int unsigned YW = POS_W + FRAC_W;
   localparam int unsigned NW = YW + 1;

   localparam logic [YW-1:0]        YSpawn  = YW'(START_Y << FRAC_W);
   localparam logic [YW-1:0]        YTopFx  = YW'(Y_MIN << FRAC_W);
   localparam logic [YW-1:0]        YBotFx  = YW'(Y_MAX << FRAC_W);
   localparam logic signed [NW-1:0] YTopCmp = NW'(Y_MIN << FRAC_W);
   localparam logic signed [NW-1:0] YBotCmp = NW'(Y_MAX << FRAC_W);
   localparam logic signed [V_W:0]  VGrav   = (V_W+1)'(GRAVITY);
   localparam logic signed [V_W:0]  VMax    = (V_W+1)'(MAX_FALL);
   localparam logic signed [V_W:0]  VJump   = (V_W+1)'(JUMP_VEL);

   typedef enum logic [1:0] {
      StInit = 2'd0,
      StFly  = 2'd1,
      StDead = 2'd2
   } state_e;

   state_e                 state_q;
   logic [YW-1:0]          y_fx_q;
   logic signed [V_W-1:0]  v_q;
   logic                   jump_q;
   logic                   hit_q;

   logic signed [V_W:0]    v_grav;
   logic signed [V_W:0]    v_next;
   logic signed [NW-1:0]   y_next;

   // Velocity is one bit wider than stored so gravity cannot wrap before the clamp.
   always_comb begin
      v_grav = {v_q[V_W-1], v_q} + VGrav;
      if (jump_q || BtnPress) begin
         v_next = -VJump;
      end else if (v_grav > VMax) begin
         v_next = VMax;
      end else begin
         v_next = v_grav;
      end
      y_next = $signed({1'b0, y_fx_q}) + $signed({{(NW-V_W-1){v_next[V_W]}}, v_next});
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= StInit;
         y_fx_q  <= YSpawn;
         v_q     <= '0;
         jump_q  <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         hit_q <= 1'b0;
         case (state_q)
            StInit: begin
               y_fx_q <= YSpawn;
               v_q    <= '0;
               jump_q <= 1'b0;
               if (Start) state_q <= StFly;
            end
            StFly: begin
               if (Collide) begin
                  // Pipe hit wins over a coincident tick; physics is frozen as-is.
                  state_q <= StDead;
                  hit_q   <= 1'b1;
                  jump_q  <= 1'b0;
               end else if (FrameTick) begin
                  jump_q <= 1'b0;
                  if (y_next <= YTopCmp) begin
                     y_fx_q <= YTopFx;
                     v_q    <= '0;
                  end else if (y_next >= YBotCmp) begin
                     y_fx_q  <= YBotFx;
                     v_q     <= '0;
                     state_q <= StDead;
                     hit_q   <= 1'b1;
                  end else begin
                     y_fx_q <= y_next[YW-1:0];
                     v_q    <= v_next[V_W-1:0];
                  end
               end else if (BtnPress) begin
                  jump_q <= 1'b1;
               end
            end
            StDead: begin
               jump_q <= 1'b0;
               if (Ack) begin
                  state_q <= StInit;
                  y_fx_q  <= YSpawn;
                  v_q     <= '0;
               end
            end
            default: begin
               state_q <= StInit;
               jump_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Bird_X    = POS_W'(START_X);
   assign Bird_Y    = y_fx_q[YW-1:FRAC_W];
   assign VertSpeed = v_q;
   assign State     = state_q;
   assign Hit       = hit_q;

endmodule

// File: tb/tb_bird_physics_fx.sv
// Self-checking bench for bird_physics_fx: directed scenarios plus random stimulus
// compared against an integer reference model of the bird physics.
module tb_bird_physics_fx;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic       Start = 1'b0, Ack = 1'b0, FrameTick = 1'b0, BtnPress = 1'b0, Collide = 1'b0;
   logic [9:0] Bird_X, Bird_Y;
   logic [9:0] VertSpeed;
   logic [1:0] State;
   logic       Hit;

   int tests = 0;
   int fails = 0;

   // Reference model, in plain integers (y in 1/16 px units).
   int m_state, m_y, m_v, m_hit;
   bit m_pend;

   bird_physics_fx dut (
      .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .FrameTick(FrameTick),
      .BtnPress(BtnPress), .Collide(Collide), .Bird_X(Bird_X), .Bird_Y(Bird_Y),
      .VertSpeed(VertSpeed), .State(State), .Hit(Hit)
   );

   always #5 Clk = ~Clk;

   function automatic int vs();
      logic signed [9:0] s;
      s = VertSpeed;
      return int'(s);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_y = 240 * 16; m_v = 0; m_pend = 0; m_hit = 0;
   endtask

   task automatic model_edge(input bit s, input bit a, input bit t, input bit b, input bit c);
      int vn, yn;
      m_hit = 0;
      case (m_state)
         0: if (s) m_state = 1;
         1: begin
            if (c) begin
               m_state = 2; m_hit = 1; m_pend = 0;
            end else if (t) begin
               if (m_pend || b) vn = -96;
               else vn = (m_v + 6 > 128) ? 128 : m_v + 6;
               yn = m_y + vn;
               if (yn <= 0) begin
                  m_y = 0; m_v = 0;
               end else if (yn >= 464 * 16) begin
                  m_y = 464 * 16; m_v = 0; m_state = 2; m_hit = 1;
               end else begin
                  m_y = yn; m_v = vn;
               end
               m_pend = 0;
            end else if (b) begin
               m_pend = 1;
            end
         end
         default: if (a) begin
            m_state = 0; m_y = 240 * 16; m_v = 0;
         end
      endcase
   endtask

   task automatic check_model(input string tag);
      check({tag, "_y"}, int'(Bird_Y), m_y / 16);
      check({tag, "_v"}, vs(), m_v);
      check({tag, "_st"}, int'(State), m_state);
      check({tag, "_hit"}, int'(Hit), m_hit);
      check({tag, "_x"}, int'(Bird_X), 160);
   endtask

   task automatic cyc(input bit s, input bit a, input bit t, input bit b, input bit c);
      @(negedge Clk);
      Start = s; Ack = a; FrameTick = t; BtnPress = b; Collide = c;
      model_edge(s, a, t, b, c);
      @(posedge Clk);
      #1;
      Start = 0; Ack = 0; FrameTick = 0; BtnPress = 0; Collide = 0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      reset = 1'b1;
      model_reset();
      #2;
      reset = 1'b0;
   endtask

   initial begin
      int prev_y, k;
      model_reset();
      #12;
      reset = 1'b0;

      // Reset state and idle with ignored inputs.
      #1;
      check_model("rst");
      check("rst_y_lit", int'(Bird_Y), 240);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 1, i[0]);
         check_model("init_idle");
      end
      check("init_y_lit", int'(Bird_Y), 240);

      // Start then three plain ticks.
      cyc(1, 0, 0, 0, 0);
      check("start_st", int'(State), 1);
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 0, 1, 0, 0);
         check_model("fall3");
         check("fall3_v_lit", vs(), 6 * i);
         check("fall3_y_lit", int'(Bird_Y), (i == 1) ? 240 : (i == 2) ? 241 : 242);
      end

      // Jump from spawn, then double press gives a single jump.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);
      check_model("jump");
      check("jump_v_lit", vs(), -96);
      check("jump_y_lit", int'(Bird_Y), 234);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);
      check("dbl_v_lit", vs(), -96);
      check("dbl_y_lit", int'(Bird_Y), 228);
      cyc(0, 0, 1, 0, 0);
      check("after_jump_v", vs(), -90);

      // Free fall to the floor.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      k = 0;
      while (State == 2'd1 && k < 200) begin
         cyc(0, 0, 1, 0, 0);
         k++;
         check_model("ff");
         if (k == 22) check("ff_sat22", vs(), 128);
         if (State == 2'd1 && k < 22) check("ff_ramp", vs(), 6 * k);
      end
      check("ff_dead", int'(State), 2);
      check("ff_hit", int'(Hit), 1);
      check("ff_floor", int'(Bird_Y), 464);
      cyc(0, 0, 1, 1, 1);
      check_model("ff_frozen");
      check("ff_hit_once", int'(Hit), 0);
      cyc(0, 1, 0, 0, 0);
      check_model("ff_ack");
      check("ff_ack_y", int'(Bird_Y), 240);

      // Repeated jumps into the ceiling.
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 45; i++) begin
         cyc(0, 0, 1, 1, 0);
         check_model("ceil");
      end
      check("ceil_y", int'(Bird_Y), 0);
      check("ceil_v", vs(), 0);
      check("ceil_st", int'(State), 1);

      // Collide together with a tick.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
      prev_y = int'(Bird_Y);
      cyc(0, 0, 1, 0, 1);
      check_model("col");
      check("col_y_hold", int'(Bird_Y), prev_y);
      check("col_hit", int'(Hit), 1);
      cyc(0, 0, 0, 0, 1);
      check("col_hit_once", int'(Hit), 0);
      cyc(1, 1, 0, 0, 0);
      check_model("startack");
      check("startack_st", int'(State), 0);

      // Async reset mid-flight with a jump pending.
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      @(negedge Clk);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      check_model("async_rst");
      @(negedge Clk);
      reset = 1'b0;
      cyc(0, 0, 1, 0, 0);
      check_model("post_rst");
      check("post_rst_y", int'(Bird_Y), 240);

      // Random stimulus against the model.
      for (int i = 0; i < 1500; i++) begin
         cyc($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
             $urandom_range(5) == 0, $urandom_range(59) == 0);
         check_model("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
